counter_load_ctrl: RTL
======================

// Module: counter_load_ctrl
// PURPOSE
//  Upstream controller for the loadable up-counter. Drives its count/load/inp and consumes its carry.
//  Turns the counter into a programmable-period tick generator: load reload value, count to all-ones, reload.
//  Provides start/stop/resume control, a one-cycle tick per period and a wrap tally.
// PARAMETERS
//  WIDTH  4  counter width; must match the driven counter
//  REP_W  8  width of wrap tally and repetition target
// PORTS
//  clock   in   1      single clock; all state updates on posedge clock
//  clear   in   1      synchronous, active-high reset
//  start   in   1      begin (IDLE) or resume (HOLD)
//  stop    in   1      pause (LOAD/RUN) or abort (HOLD)
//  reload  in   WIDTH  counter start value, captured on start from IDLE
//  reps    in   REP_W  repetition target (used only with LOAD_CTRL_BURST_EN)
//  carry   in   1      terminal-count flag from counter (count & ~load & out==all-ones)
//  count   out  1      counter enable
//  load    out  1      counter synchronous load strobe
//  inp     out  WIDTH  counter load data (registered copy of reload)
//  tick    out  1      one-cycle pulse per completed period
//  busy    out  1      high in LOAD, RUN and HOLD
//  done    out  1      one-cycle pulse when burst completes
//  wraps   out  REP_W  completed periods since last start from IDLE
// BEHAVIOUR
//  All outputs registered. clear=1 at posedge: IDLE, count=0, load=0, inp=0, tick=0, busy=0, done=0, wraps=0.
//  clear has priority over all inputs and is honoured mid-operation. The counter is not cleared by this block.
//  States:
//   IDLE: start=1 -> LOAD; inp<=reload, wraps<=0.
//   LOAD: load=1, count=0 for exactly one cycle; -> RUN.
//   RUN:  count=1, load=0.
//   HOLD: count=0, load=0; start -> RUN (no reload, counter value kept); stop -> IDLE.
//  Stop priority:
//   stop=1 in LOAD or RUN -> HOLD.
//   stop has priority over start when both are high; start+stop in IDLE stays IDLE.
//  Carry handling (RUN only):
//   carry=1 sampled at an edge (counter wraps to 0 on that edge) -> LOAD.
//   Same edge: tick<=1 for one cycle, wraps<=wraps+1 (modulo 2^REP_W).
//   carry is ignored in IDLE, LOAD and HOLD.
//  Period (load edge to load edge) = 2^WIDTH - reload + 1 clocks.
//   Sequence: reload..all-ones, then one cycle at 0. E.g. WIDTH=4, reload=12: period 5.
//  reload changes after capture are ignored until the next start from IDLE.
// CONFIGURATION
//  LOAD_CTRL_BURST_EN defined:
//   When a wrap makes wraps==reps and reps!=0: -> IDLE instead of LOAD. tick=1 and done=1 on the same cycle.
//   reps=0 means free-running.
//  LOAD_CTRL_BURST_EN undefined:
//   reps ignored, done tied 0, free-running until stop.
// STRUCTURE
//  Shared package counter_pkg:
//   state encoding IDLE=2'd0, LOAD=2'd1, RUN=2'd2, HOLD=2'd3;
//   default WIDTH/REP_W constants.
//  One sub-module: load_ctrl_reps (REP_W wrap tally, clear/increment, reps compare -> burst_hit).
// TESTING (WIDTH=4, counter instantiated in bench)
//  1. clear=1 for 2 cycles, then start=1 for 1 cycle with reload=12
//     -> load high 1 cycle; counter 12,13,14,15,0,12...; tick every 5 clocks; wraps 1,2,3.
//  2. reload=15 -> period 2 (15,0); reload=0 -> period 17; tick spacing checked exactly.
//  3. stop mid-RUN at counter=13 -> count=0, counter holds 13, busy=1;
//     start -> resumes at 13 with no load; second stop in HOLD -> IDLE, busy=0.
//  4. start and stop high together in RUN -> HOLD; together in IDLE -> stays IDLE.
//     clear in RUN -> all outputs 0 next cycle.
//  5. BURST_EN, reload=14, reps=3 -> 3 ticks spaced 3 clocks; done coincident with third tick; then IDLE, count=0.
//  6. BURST_EN, reps=0 -> free-running past 255 wraps; wraps rolls 255->0, done never asserted.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counter load controller.
// Contents: controller state encoding and default WIDTH / REP_W sizes.
// No ports.
package counter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2,
        StHold = 2'd3
    } state_e;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_REP_W = 8;

endpackage

// File: rtl/load_ctrl_reps.sv
// Wrap tally for the counter load controller.
// Counts completed periods modulo 2^REP_W and flags when the next wrap hits the target.
// Ports:
//   clock      in   1      posedge clock
//   clear      in   1      synchronous active-high reset
//   restart    in   1      zero the tally (start from IDLE)
//   wrap       in   1      a period completed this cycle; increment
//   reps       in   REP_W  repetition target, 0 = no target
//   wraps      out  REP_W  registered tally
//   burst_hit  out  1      the increment happening now reaches a non-zero target
module load_ctrl_reps
    import counter_pkg::*;
#(
    parameter int unsigned REP_W = DEF_REP_W
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             restart,
    input  logic             wrap,
    input  logic [REP_W-1:0] reps,
    output logic [REP_W-1:0] wraps,
    output logic             burst_hit
);

    logic [REP_W-1:0] wraps_q;
    logic [REP_W-1:0] wraps_inc;

    assign wraps_inc = wraps_q + REP_W'(1);

    always_ff @(posedge clock) begin
        if (clear) begin
            wraps_q <= '0;
        end else if (restart) begin
            wraps_q <= '0;
        end else if (wrap) begin
            wraps_q <= wraps_inc;
        end
    end

    // Looks at the post-increment value so the top can leave on the same edge.
    assign burst_hit = (reps != '0) && (wraps_inc == reps);
    assign wraps     = wraps_q;

endmodule

// File: rtl/counter_load_ctrl.sv
// Upstream controller that turns a loadable up-counter into a programmable-period
// tick generator: load the reload value, count to all-ones, reload, repeat.
// Optional feature macro: LOAD_CTRL_BURST_EN (stop after reps periods, pulse done).
// Ports:
//   clock   in   1      posedge clock
//   clear   in   1      synchronous active-high reset, highest priority
//   start   in   1      begin from IDLE, resume from HOLD
//   stop    in   1      pause from LOAD/RUN, abort from HOLD; beats start
//   reload  in   WIDTH  counter start value, captured on start from IDLE
//   reps    in   REP_W  repetition target (burst build only)
//   carry   in   1      counter terminal count
//   count   out  1      counter enable
//   load    out  1      counter load strobe
//   inp     out  WIDTH  counter load data
//   tick    out  1      one-cycle pulse per completed period
//   busy    out  1      high in LOAD, RUN, HOLD
//   done    out  1      one-cycle pulse when a burst completes
//   wraps   out  REP_W  completed periods since last start from IDLE
module counter_load_ctrl
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned REP_W = DEF_REP_W
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] reload,
    input  logic [REP_W-1:0] reps,
    input  logic             carry,
    output logic             count,
    output logic             load,
    output logic [WIDTH-1:0] inp,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] wraps
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] inp_q, inp_d;
    logic             count_q, load_q, tick_q, busy_q, done_q;
    logic             tick_d, done_d;
    logic             restart, wrap, burst_hit, burst_stop;

    load_ctrl_reps #(
        .REP_W (REP_W)
    ) u_reps (
        .clock     (clock),
        .clear     (clear),
        .restart   (restart),
        .wrap      (wrap),
        .reps      (reps),
        .wraps     (wraps),
        .burst_hit (burst_hit)
    );

`ifdef LOAD_CTRL_BURST_EN
    assign burst_stop = burst_hit;
`else
    logic unused_burst;
    assign burst_stop   = 1'b0;
    assign unused_burst = ^{reps, burst_hit};
`endif

    always_comb begin
        state_d = state_q;
        inp_d   = inp_q;
        restart = 1'b0;
        wrap    = 1'b0;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d = StLoad;
                    inp_d   = reload;
                    restart = 1'b1;
                end
            end
            StLoad: begin
                state_d = stop ? StHold : StRun;
            end
            StRun: begin
                if (stop) begin
                    state_d = StHold;
                end else if (carry) begin
                    // Counter wraps to 0 on this edge; reload on the next.
                    wrap   = 1'b1;
                    tick_d = 1'b1;
                    if (burst_stop) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StHold: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (start) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered as a function of the next state.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= StIdle;
            inp_q   <= '0;
            count_q <= 1'b0;
            load_q  <= 1'b0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inp_q   <= inp_d;
            count_q <= (state_d == StRun);
            load_q  <= (state_d == StLoad);
            tick_q  <= tick_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign load  = load_q;
    assign inp   = inp_q;
    assign tick  = tick_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
